// File: rtl/acc_group_pkg.sv
// Shared definitions for the accumulation stage: state encoding and defaults.
// Optional saturation is selected with ACC_GROUP_SATURATE_EN.
package acc_group_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int DEFAULT_ACC_WIDTH = 32;
    localparam string DEBUG_HOOK = "DEBUG_ACC_GROUP";
endpackage

// File: rtl/acc_lane.sv
// One accumulator lane: sums products, snapshots the total on the last read of a group.
// With ACC_GROUP_SATURATE_EN a carry-out clamps the lane to all-ones.
module acc_lane
    import acc_group_pkg::*;
#(
    parameter int PROD_WIDTH = 16,
    parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  add_en,
    input  logic                  last,
    input  logic [PROD_WIDTH-1:0] prod,
    output logic [ACC_WIDTH-1:0]  result
);
    logic [ACC_WIDTH-1:0] acc, nxt;

`ifdef ACC_GROUP_SATURATE_EN
    logic [ACC_WIDTH:0] sum;
    assign sum = {1'b0, acc} + (ACC_WIDTH+1)'(prod);
    // Once clamped, further adds carry again (or add zero), so the clamp is sticky.
    assign nxt = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
    assign nxt = acc + ACC_WIDTH'(prod);
`endif

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            acc    <= '0;
            result <= '0;
        end else if (add_en) begin
            if (last) begin
                result <= nxt;
                acc    <= '0;
            end else begin
                acc <= nxt;
            end
        end
    end
endmodule

// File: rtl/fifo.sv
// Small circular FIFO; writes into a full FIFO and reads from an empty one are ignored.
module fifo #(
    parameter int NUM_SLOTS     = 2,
    parameter int LOG_NUM_SLOTS = 1,
    parameter int DATA_WIDTH    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty
);
    logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
    logic [LOG_NUM_SLOTS-1:0] wp, rp;
    logic [LOG_NUM_SLOTS:0] cnt;
    logic do_wr, do_rd;

    assign full        = cnt == (LOG_NUM_SLOTS+1)'(NUM_SLOTS);
    assign almost_full = cnt == (LOG_NUM_SLOTS+1)'(NUM_SLOTS-1);
    assign empty       = cnt == '0;
    assign do_wr       = wr & ~full;
    assign do_rd       = rd & ~empty;
    assign data_out    = mem[rp];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) wp <= (wp == LOG_NUM_SLOTS'(NUM_SLOTS-1)) ? '0 : wp + 1'b1;
            if (do_rd) rp <= (rp == LOG_NUM_SLOTS'(NUM_SLOTS-1)) ? '0 : rp + 1'b1;
            if (do_wr & ~do_rd)      cnt <= cnt + 1'b1;
            else if (~do_wr & do_rd) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= data_in;
    end
endmodule

// File: rtl/acc_group.sv
// Accumulation stage: sums GROUP_SIZE product lanes over num_reads_per_iter transfers,
// emitting num_iters results. Saturating lanes with ACC_GROUP_SATURATE_EN.
module acc_group
    import acc_group_pkg::*;
#(
    parameter int GROUP_SIZE             = 4,
    parameter int PROD_WIDTH             = 16,
    parameter int ACC_WIDTH              = DEFAULT_ACC_WIDTH,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              configure,
    input  logic [LOG_MAX_ITERS-1:0]          num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
    input  logic [GROUP_SIZE*PROD_WIDTH-1:0]  data_in,
    input  logic                              valid_in,
    output logic                              avail_out,
    output logic [GROUP_SIZE*ACC_WIDTH-1:0]   data_out,
    output logic                              valid_out,
    input  logic                              avail_in
);
    localparam int DW = GROUP_SIZE * PROD_WIDTH;

    state_t state;
    logic [LOG_MAX_ITERS-1:0] iters;
    logic [LOG_MAX_READS_PER_ITER-1:0] reads, reads_copy;
    logic [DW-1:0] fifo_q;
    logic full, almost_full, empty, rd, last;

    assign rd        = (state == RUN) & ~empty & ~configure;
    assign last      = rd & (reads == LOG_MAX_READS_PER_ITER'(1));
    assign avail_out = ~full & ~almost_full;
    assign valid_out = (state == FLUSH) & avail_in & ~configure;

    fifo #(
        .NUM_SLOTS    (2),
        .LOG_NUM_SLOTS(1),
        .DATA_WIDTH   (DW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .wr         (valid_in),
        .rd         (rd),
        .data_out   (fifo_q),
        .full       (full),
        .almost_full(almost_full),
        .empty      (empty)
    );

    for (genvar i = 0; i < GROUP_SIZE; i++) begin : g_lane
        acc_lane #(
            .PROD_WIDTH(PROD_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (configure),
            .add_en(rd),
            .last  (last),
            .prod  (fifo_q[i*PROD_WIDTH +: PROD_WIDTH]),
            .result(data_out[i*ACC_WIDTH +: ACC_WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            iters      <= '0;
            reads      <= '0;
            reads_copy <= '0;
        end else if (configure) begin
            iters      <= num_iters;
            reads      <= num_reads_per_iter;
            reads_copy <= num_reads_per_iter;
            state      <= (num_iters == '0 || num_reads_per_iter == '0) ? IDLE : RUN;
        end else begin
            case (state)
                RUN: if (rd) begin
                    reads <= reads - 1'b1;
                    if (last) state <= FLUSH;
                end
                FLUSH: if (avail_in) begin
                    if (iters == LOG_MAX_ITERS'(1)) begin
                        state <= IDLE;
                    end else begin
                        iters <= iters - 1'b1;
                        reads <= reads_copy;
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_group.sv
// Randomized self-checking bench for acc_group with a transaction-level model and directed pins.
module tb_acc_group;
    localparam int GS = 4, PW = 16, AW = 16, LI = 16, LR = 16;
    localparam longint unsigned MAXV = (longint'(1) << AW) - 1;

    logic clk = 0, rst = 0, configure = 0, valid_in = 0, avail_in = 0;
    logic [LI-1:0] num_iters = '0;
    logic [LR-1:0] num_reads = '0;
    logic [GS*PW-1:0] data_in = '0;
    logic avail_out, valid_out;
    logic [GS*AW-1:0] data_out;

    acc_group #(
        .GROUP_SIZE(GS), .PROD_WIDTH(PW), .ACC_WIDTH(AW),
        .LOG_MAX_ITERS(LI), .LOG_MAX_READS_PER_ITER(LR)
    ) dut (
        .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
        .num_reads_per_iter(num_reads), .data_in(data_in), .valid_in(valid_in),
        .avail_out(avail_out), .data_out(data_out), .valid_out(valid_out),
        .avail_in(avail_in)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: job description (results left, reads left) plus a 2-deep queue.
    bit checking = 0;
    bit m_waiting;             // a result is waiting to be handed downstream
    bit m_active;              // consuming transfers
    logic [GS*PW-1:0] m_q[$];
    longint unsigned m_sum[GS], m_out[GS];
    int m_iters, m_left, m_copy;

    function automatic longint unsigned add(longint unsigned a, longint unsigned b);
        longint unsigned s = a + b;
`ifdef ACC_GROUP_SATURATE_EN
        if (s > MAXV) s = MAXV;
`else
        s = s & MAXV;
`endif
        return s;
    endfunction

    function automatic logic [GS*AW-1:0] m_packed();
        logic [GS*AW-1:0] r;
        for (int i = 0; i < GS; i++) r[i*AW +: AW] = m_out[i][AW-1:0];
        return r;
    endfunction

    always @(posedge clk) begin : model
        int sz;
        logic [GS*PW-1:0] f;
        if (!rst) begin
            m_q.delete();
            m_waiting = 0; m_active = 0;
            m_iters = 0; m_left = 0; m_copy = 0;
            for (int i = 0; i < GS; i++) begin m_sum[i] = 0; m_out[i] = 0; end
        end else begin
            sz = m_q.size();
            if (configure) begin
                m_iters = num_iters; m_left = num_reads; m_copy = num_reads;
                m_waiting = 0;
                m_active = (num_iters != 0) && (num_reads != 0);
                for (int i = 0; i < GS; i++) begin m_sum[i] = 0; m_out[i] = 0; end
            end else if (m_active && sz > 0) begin
                f = m_q.pop_front();
                for (int i = 0; i < GS; i++) m_sum[i] = add(m_sum[i], longint'(f[i*PW +: PW]));
                m_left--;
                if (m_left == 0) begin
                    for (int i = 0; i < GS; i++) begin m_out[i] = m_sum[i]; m_sum[i] = 0; end
                    m_active = 0; m_waiting = 1;
                end
            end else if (m_waiting && avail_in) begin
                m_waiting = 0;
                m_iters--;
                if (m_iters > 0) begin m_left = m_copy; m_active = 1; end
            end
            if (valid_in && sz < 2) m_q.push_back(data_in);
        end
    end

    int pulses = 0;
    logic [GS*AW-1:0] last_res = '0;
    always @(negedge clk) begin : compare
        #2;
        if (checking) begin
            chk("valid_out", valid_out, m_waiting && avail_in && !configure);
            chk("data_out", data_out, m_packed());
            chk("avail_out", avail_out, m_q.size() == 0);
            if (valid_out === 1'b1) begin pulses++; last_res = data_out; end
        end
    end

    function automatic logic [GS*PW-1:0] lanes(int a, int b, int c, int d);
        return {PW'(d), PW'(c), PW'(b), PW'(a)};
    endfunction

    task automatic nxt(); @(negedge clk); configure = 0; valid_in = 0; endtask
    task automatic cfg(int ni, int nr); nxt(); configure = 1; num_iters = LI'(ni); num_reads = LR'(nr); endtask
    task automatic put(logic [GS*PW-1:0] d); nxt(); valid_in = 1; data_in = d; endtask
    task automatic idle(int n); repeat (n) nxt(); endtask
    task automatic do_reset(); nxt(); rst = 0; nxt(); rst = 1; endtask

    initial begin
        int p0;
        logic [15:0] exp_sat;
        do_reset();
        checking = 1;

        // 1: single group of three transfers
        avail_in = 1; p0 = pulses;
        cfg(1, 3);
        put(lanes(1, 2, 3, 4)); put(lanes(10, 20, 30, 40)); put(lanes(100, 200, 300, 400));
        idle(6);
        chk("t1_pulses", 64'(pulses - p0), 64'd1);
        chk("t1_data", last_res, lanes(111, 222, 333, 444));

        // 2: downstream stall while upstream keeps writing
        avail_in = 0; p0 = pulses;
        cfg(2, 2);
        put(lanes(1, 1, 1, 1)); put(lanes(2, 2, 2, 2));
        put(lanes(5, 6, 7, 8)); put(lanes(7, 7, 7, 7));
        put(lanes(99, 99, 99, 99)); put(lanes(99, 99, 99, 99)); put(lanes(99, 99, 99, 99));
        #3;
        chk("t2_hold_valid", valid_out, 1'b0);
        chk("t2_hold_avail", avail_out, 1'b0);
        chk("t2_hold_data", data_out, lanes(3, 3, 3, 3));
        nxt(); avail_in = 1;
        idle(8);
        chk("t2_pulses", 64'(pulses - p0), 64'd2);
        chk("t2_second", last_res, lanes(12, 13, 14, 15));

        // 3: lane overflow
        cfg(1, 2);
        put(lanes(16'hFFFF, 0, 0, 0)); put(lanes(2, 0, 0, 0));
        idle(5);
`ifdef ACC_GROUP_SATURATE_EN
        exp_sat = 16'hFFFF;
`else
        exp_sat = 16'h0001;
`endif
        chk("t3_lane0", 64'(last_res[15:0]), 64'(exp_sat));

        // 4: reconfigure mid-group drops the partial sum
        p0 = pulses;
        cfg(1, 3); put(lanes(50, 50, 50, 50)); idle(2);
        cfg(1, 1); put(lanes(5, 6, 7, 8)); idle(5);
        chk("t4_pulses", 64'(pulses - p0), 64'd1);
        chk("t4_data", last_res, lanes(5, 6, 7, 8));

        // 5: reset while holding a result
        avail_in = 0;
        cfg(1, 1); put(lanes(9, 9, 9, 9)); idle(3);
        nxt(); rst = 0;
        nxt(); rst = 1; avail_in = 1;
        #2;
        chk("t5_valid", valid_out, 1'b0);
        chk("t5_data", data_out, 64'd0);
        chk("t5_avail", avail_out, 1'b1);
        cfg(1, 1); put(lanes(4, 3, 2, 1)); idle(5);
        chk("t5_after", last_res, lanes(4, 3, 2, 1));

        // 6: zero reads per iteration leaves the FIFO untouched
        p0 = pulses;
        cfg(2, 0);
        put(lanes(1, 1, 1, 1)); put(lanes(2, 2, 2, 2)); put(lanes(3, 3, 3, 3));
        #3;
        chk("t6_avail", avail_out, 1'b0);
        idle(4);
        chk("t6_pulses", 64'(pulses - p0), 64'd0);
        do_reset();

        // random phase
        for (int c = 0; c < 4000; c++) begin
            nxt();
            rst = ($urandom % 300) != 0;
            if ($urandom % 100 < 4) begin
                configure = 1;
                num_iters = LI'($urandom % 4);
                num_reads = LR'($urandom % 5);
            end
            valid_in = ($urandom % 3) != 0;
            for (int i = 0; i < GS; i++)
                data_in[i*PW +: PW] = ($urandom % 4 == 0) ? PW'(16'hFFF0 + $urandom % 16) : PW'($urandom % 256);
            avail_in = ($urandom % 4) != 0;
        end
        nxt(); rst = 1;
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
